// File: rtl/riscv_if_fetch_ctrl.sv
// IF-stage fetch controller: issues in-order instruction-memory requests, tracks
// outstanding reads, buffers returned parcels and presents them to IF.
module riscv_if_fetch_ctrl #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int MAX_OUT     = 2,
  parameter int BUF_DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           if_nxt_pc,
  input  logic                      if_stall,
  input  logic                      if_flush,
  output logic                      if_stall_nxt_pc,
  output logic [PARCEL_SIZE-1:0]    if_parcel,
  output logic [XLEN-1:0]           if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                      if_parcel_misaligned,
  output logic                      if_parcel_page_fault,
  output logic                      mem_req,
  output logic [XLEN-1:0]           mem_adr,
  input  logic                      mem_ack,
  input  logic                      mem_rvalid,
  input  logic [PARCEL_SIZE-1:0]    mem_rdata,
  input  logic                      mem_err
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int BW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int QW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]          out_cnt_q, out_cnt_d;
  logic [CW-1:0]          discard_cnt_q, discard_cnt_d;
  logic [XLEN-1:0]        pcf_q [MAX_OUT];
  logic [XLEN-1:0]        pcf_d [MAX_OUT];
  logic [PW-1:0]          pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;

  logic [PARCEL_SIZE-1:0] buf_data_q [BUF_DEPTH];
  logic [PARCEL_SIZE-1:0] buf_data_d [BUF_DEPTH];
  logic [XLEN-1:0]        buf_pc_q   [BUF_DEPTH];
  logic [XLEN-1:0]        buf_pc_d   [BUF_DEPTH];
  logic                   buf_err_q  [BUF_DEPTH];
  logic                   buf_err_d  [BUF_DEPTH];
  logic                   buf_mis_q  [BUF_DEPTH];
  logic                   buf_mis_d  [BUF_DEPTH];
  logic [QW-1:0]          buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [BW-1:0]          buf_cnt_q, buf_cnt_d;

  logic [PARCEL_SIZE-1:0]    parcel_q, parcel_d;
  logic [XLEN-1:0]           parcel_pc_q, parcel_pc_d;
  logic [PARCEL_SIZE/16-1:0] parcel_valid_q, parcel_valid_d;
  logic                      parcel_mis_q, parcel_mis_d;
  logic                      parcel_pf_q, parcel_pf_d;

  logic                   aligned, credit, accept, marker, rsp_push, push;
  logic                   buf_empty, deliver, bypass, buf_push, buf_pop, drain_dec;
  logic [CW-1:0]          flush_left;
  logic [PARCEL_SIZE-1:0] in_data;
  logic [XLEN-1:0]        in_pc;
  logic                   in_err, in_mis;

  function automatic logic [PW-1:0] pcf_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [QW-1:0] buf_inc(input logic [QW-1:0] p);
    return (p == QW'(BUF_DEPTH - 1)) ? '0 : p + QW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (if_flush && (flush_left != '0)) state_d = ST_DRAIN;
      ST_DRAIN: if ((discard_cnt_q == '0) || (drain_dec && (discard_cnt_q == CW'(1))))
                  state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    aligned    = (if_nxt_pc[1:0] == 2'b00);
    credit     = ((int'(out_cnt_q) + int'(buf_cnt_q)) < BUF_DEPTH) && (out_cnt_q < CW'(MAX_OUT));
    mem_req    = (state_q == ST_RUN) && credit && !if_flush && aligned;
    mem_adr    = if_nxt_pc;
    accept     = mem_req && mem_ack;
    marker     = (state_q == ST_RUN) && credit && !if_flush && !aligned && (out_cnt_q == '0);
    if_stall_nxt_pc = !(accept || marker);
    rsp_push   = (state_q == ST_RUN) && !if_flush && mem_rvalid;
    push       = rsp_push || marker;
    flush_left = out_cnt_q - CW'(mem_rvalid && (out_cnt_q != '0));
    drain_dec  = (state_q == ST_DRAIN) && mem_rvalid && (discard_cnt_q != '0);
    in_data    = marker ? '0 : mem_rdata;
    in_pc      = marker ? if_nxt_pc : pcf_q[pcf_rd_q];
    in_err     = marker ? 1'b0 : mem_err;
    in_mis     = marker;
    // An empty buffer lets the incoming entry go straight to the output
    // registers, giving the two-cycle ack-to-parcel latency.
    buf_empty  = (buf_cnt_q == '0);
    deliver    = !if_flush && !if_stall && (!buf_empty || push);
    bypass     = deliver && buf_empty;
    buf_push   = push && !bypass;
    buf_pop    = deliver && !buf_empty;
  end

  always_comb begin
    out_cnt_d      = out_cnt_q;
    discard_cnt_d  = discard_cnt_q;
    pcf_d          = pcf_q;
    pcf_wr_d       = pcf_wr_q;
    pcf_rd_d       = pcf_rd_q;
    buf_data_d     = buf_data_q;
    buf_pc_d       = buf_pc_q;
    buf_err_d      = buf_err_q;
    buf_mis_d      = buf_mis_q;
    buf_wr_d       = buf_wr_q;
    buf_rd_d       = buf_rd_q;
    buf_cnt_d      = buf_cnt_q;
    parcel_d       = parcel_q;
    parcel_pc_d    = parcel_pc_q;
    parcel_mis_d   = parcel_mis_q;
    parcel_pf_d    = parcel_pf_q;
    parcel_valid_d = '0;
    if (drain_dec) discard_cnt_d = discard_cnt_q - CW'(1);
    if (if_flush) begin
      out_cnt_d = '0;
      pcf_wr_d  = '0;
      pcf_rd_d  = '0;
      buf_wr_d  = '0;
      buf_rd_d  = '0;
      buf_cnt_d = '0;
      if (state_q == ST_RUN) discard_cnt_d = flush_left;
    end else begin
      if (accept) begin
        pcf_d[pcf_wr_q] = if_nxt_pc;
        pcf_wr_d        = pcf_inc(pcf_wr_q);
      end
      if (rsp_push) pcf_rd_d = pcf_inc(pcf_rd_q);
      if (accept && !rsp_push)      out_cnt_d = out_cnt_q + CW'(1);
      else if (!accept && rsp_push) out_cnt_d = out_cnt_q - CW'(1);
      if (buf_push) begin
        buf_data_d[buf_wr_q] = in_data;
        buf_pc_d[buf_wr_q]   = in_pc;
        buf_err_d[buf_wr_q]  = in_err;
        buf_mis_d[buf_wr_q]  = in_mis;
        buf_wr_d             = buf_inc(buf_wr_q);
      end
      if (buf_pop) buf_rd_d = buf_inc(buf_rd_q);
      if (buf_push && !buf_pop)      buf_cnt_d = buf_cnt_q + BW'(1);
      else if (!buf_push && buf_pop) buf_cnt_d = buf_cnt_q - BW'(1);
      if (deliver) begin
        parcel_d       = bypass ? in_data : buf_data_q[buf_rd_q];
        parcel_pc_d    = bypass ? in_pc   : buf_pc_q[buf_rd_q];
        parcel_pf_d    = bypass ? in_err  : buf_err_q[buf_rd_q];
        parcel_mis_d   = bypass ? in_mis  : buf_mis_q[buf_rd_q];
        parcel_valid_d = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q      <= '0;
      discard_cnt_q  <= '0;
      pcf_wr_q       <= '0;
      pcf_rd_q       <= '0;
      buf_wr_q       <= '0;
      buf_rd_q       <= '0;
      buf_cnt_q      <= '0;
      parcel_q       <= '0;
      parcel_pc_q    <= '0;
      parcel_valid_q <= '0;
      parcel_mis_q   <= 1'b0;
      parcel_pf_q    <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUT; i++) pcf_q[i] <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
        buf_err_q[i]  <= 1'b0;
        buf_mis_q[i]  <= 1'b0;
      end
    end else begin
      out_cnt_q      <= out_cnt_d;
      discard_cnt_q  <= discard_cnt_d;
      pcf_q          <= pcf_d;
      pcf_wr_q       <= pcf_wr_d;
      pcf_rd_q       <= pcf_rd_d;
      buf_data_q     <= buf_data_d;
      buf_pc_q       <= buf_pc_d;
      buf_err_q      <= buf_err_d;
      buf_mis_q      <= buf_mis_d;
      buf_wr_q       <= buf_wr_d;
      buf_rd_q       <= buf_rd_d;
      buf_cnt_q      <= buf_cnt_d;
      parcel_q       <= parcel_d;
      parcel_pc_q    <= parcel_pc_d;
      parcel_valid_q <= parcel_valid_d;
      parcel_mis_q   <= parcel_mis_d;
      parcel_pf_q    <= parcel_pf_d;
    end
  end

  assign if_parcel            = parcel_q;
  assign if_parcel_pc         = parcel_pc_q;
  assign if_parcel_valid      = parcel_valid_q;
  assign if_parcel_misaligned = parcel_mis_q;
  assign if_parcel_page_fault = parcel_pf_q;

endmodule

// File: tb/tb_riscv_if_fetch_ctrl.sv
// Directed bench for riscv_if_fetch_ctrl with a small in-order memory model.
module tb_riscv_if_fetch_ctrl;
  localparam int XLEN = 32;
  localparam int PS   = 32;
  localparam int VW   = PS / 16;
  localparam logic [VW-1:0] VALL = '1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] if_nxt_pc;
  logic            if_stall, if_flush, if_stall_nxt_pc;
  logic [PS-1:0]   if_parcel;
  logic [XLEN-1:0] if_parcel_pc;
  logic [VW-1:0]   if_parcel_valid;
  logic            if_parcel_misaligned, if_parcel_page_fault;
  logic            mem_req, mem_ack, mem_rvalid, mem_err;
  logic [XLEN-1:0] mem_adr;
  logic [PS-1:0]   mem_rdata;

  riscv_if_fetch_ctrl #(.XLEN(XLEN), .PARCEL_SIZE(PS), .MAX_OUT(2), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .if_nxt_pc(if_nxt_pc), .if_stall(if_stall), .if_flush(if_flush),
    .if_stall_nxt_pc(if_stall_nxt_pc), .if_parcel(if_parcel), .if_parcel_pc(if_parcel_pc),
    .if_parcel_valid(if_parcel_valid), .if_parcel_misaligned(if_parcel_misaligned),
    .if_parcel_page_fault(if_parcel_page_fault), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [PS-1:0]   data;
    logic            mis;
    logic            pf;
    logic [VW-1:0]   v;
    int              cyc;
  } parcel_t;

  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  bit              rsp_en, pc_auto;
  logic [XLEN-1:0] err_adr;
  logic            s_req;
  logic [XLEN-1:0] pend[$];
  logic [XLEN-1:0] acc_log[$];
  int              acc_cyc[$];
  parcel_t         got[$];

  function automatic logic [PS-1:0] mdata(input logic [XLEN-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // One clock: sample at negedge, then update memory model and PC after the edge.
  task automatic tick();
    parcel_t         p;
    logic            acc, nxt;
    logic [XLEN-1:0] a, r;
    @(negedge clk);
    cyc++;
    s_req = mem_req;
    acc   = mem_req && mem_ack;
    a     = mem_adr;
    nxt   = !if_stall_nxt_pc;
    if (if_parcel_valid != '0) begin
      p.pc = if_parcel_pc; p.data = if_parcel; p.mis = if_parcel_misaligned;
      p.pf = if_parcel_page_fault; p.v = if_parcel_valid; p.cyc = cyc;
      got.push_back(p);
    end
    @(posedge clk); #1;
    if (acc) begin
      acc_log.push_back(a);
      acc_cyc.push_back(cyc);
      pend.push_back(a);
    end
    if (nxt && pc_auto) if_nxt_pc = if_nxt_pc + 32'd4;
    if (rsp_en && pend.size() != 0) begin
      r = pend.pop_front();
      mem_rvalid = 1'b1; mem_rdata = mdata(r); mem_err = (r == err_adr);
    end else begin
      mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int b;
    b = budget;
    while (got.size() < n && b > 0) begin
      tick();
      b--;
    end
  endtask

  task automatic do_reset(input logic [XLEN-1:0] pc);
    rst = 1'b1;
    if_flush = 1'b0; if_stall = 1'b0; mem_ack = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    if_nxt_pc = pc; rsp_en = 1'b1; pc_auto = 1'b1; err_adr = '1;
    pend.delete(); got.delete(); acc_log.delete(); acc_cyc.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mem_ack = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_flush = 1'b0; if_stall = 1'b0; mem_ack = 1'b1; if_nxt_pc = 32'h200;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (if_stall_nxt_pc !== 1'b1) begin errors++; $display("FAIL reset_stall_nxt: got %b expected 1", if_stall_nxt_pc); end
    checks++; if (if_parcel_valid !== '0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_parcel_valid); end
    checks++; if (if_parcel !== '0) begin errors++; $display("FAIL reset_parcel: got %h expected 0", if_parcel); end
    checks++; if (if_parcel_pc !== '0) begin errors++; $display("FAIL reset_pc: got %h expected 0", if_parcel_pc); end
    checks++; if (if_parcel_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b expected 0", if_parcel_misaligned); end
    checks++; if (if_parcel_page_fault !== 1'b0) begin errors++; $display("FAIL reset_pf: got %b expected 0", if_parcel_page_fault); end
  endtask

  task automatic test_fetch();
    do_reset(32'h200);
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL boot_no_req: got %b expected 0", s_req); end
    run_until(3, 20);
    checks++;
    if (got.size() < 3 || acc_cyc.size() < 1) begin
      errors++; $display("FAIL fetch_count: got %0d parcels expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got[i].pc !== 32'h200 + 32'(4 * i)) begin errors++; $display("FAIL fetch_pc%0d: got %h expected %h", i, got[i].pc, 32'h200 + 32'(4 * i)); end
        checks++; if (got[i].data !== mdata(32'h200 + 32'(4 * i))) begin errors++; $display("FAIL fetch_data%0d: got %h expected %h", i, got[i].data, mdata(32'h200 + 32'(4 * i))); end
      end
      checks++; if (got[0].cyc - acc_cyc[0] != 2) begin errors++; $display("FAIL fetch_latency: got %0d expected 2", got[0].cyc - acc_cyc[0]); end
      checks++; if (got[2].cyc - got[0].cyc != 2) begin errors++; $display("FAIL fetch_back_to_back: got %0d expected 2", got[2].cyc - got[0].cyc); end
      checks++; if (got[0].v !== VALL) begin errors++; $display("FAIL fetch_valid: got %b expected %b", got[0].v, VALL); end
    end
  endtask

  task automatic test_stall();
    do_reset(32'h200);
    if_stall = 1'b1;
    repeat (8) tick();
    checks++; if (acc_log.size() != 2) begin errors++; $display("FAIL stall_accepts: got %0d expected 2", acc_log.size()); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL stall_no_parcel: got %0d expected 0", got.size()); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL stall_req_drop: got %b expected 0", s_req); end
    if_stall = 1'b0;
    run_until(4, 30);
    checks++;
    if (got.size() < 4) begin
      errors++; $display("FAIL stall_count: got %0d expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got[i].pc !== 32'h200 + 32'(4 * i)) begin errors++; $display("FAIL stall_pc%0d: got %h expected %h", i, got[i].pc, 32'h200 + 32'(4 * i)); end
        checks++; if (got[i].data !== mdata(32'h200 + 32'(4 * i))) begin errors++; $display("FAIL stall_data%0d: got %h expected %h", i, got[i].data, mdata(32'h200 + 32'(4 * i))); end
      end
    end
  endtask

  task automatic test_flush_drain();
    int b;
    do_reset(32'h200);
    rsp_en = 1'b0;
    b = 10;
    while (acc_log.size() < 2 && b > 0) begin tick(); b--; end
    tick();
    checks++; if (acc_log.size() != 2) begin errors++; $display("FAIL drain_outstanding: got %0d expected 2", acc_log.size()); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL drain_credit_req: got %b expected 0", s_req); end
    if_flush = 1'b1; if_nxt_pc = 32'h400;
    tick();
    if_flush = 1'b0; rsp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL drain_req%0d: got %b expected 0", i, s_req); end
    end
    run_until(1, 10);
    checks++;
    if (got.size() < 1 || acc_log.size() < 3) begin
      errors++; $display("FAIL drain_count: got %0d parcels expected 1", got.size());
    end else begin
      checks++; if (got[0].pc !== 32'h400) begin errors++; $display("FAIL drain_pc: got %h expected 400", got[0].pc); end
      checks++; if (got[0].data !== mdata(32'h400)) begin errors++; $display("FAIL drain_data: got %h expected %h", got[0].data, mdata(32'h400)); end
      checks++; if (acc_log[2] !== 32'h400) begin errors++; $display("FAIL drain_next_req: got %h expected 400", acc_log[2]); end
    end
  endtask

  task automatic test_flush_with_rvalid();
    int b;
    do_reset(32'h200);
    rsp_en = 1'b0;
    b = 10;
    while (acc_log.size() < 1 && b > 0) begin tick(); b--; end
    mem_ack = 1'b0; rsp_en = 1'b1;
    tick();
    checks++; if (mem_rvalid !== 1'b1) begin errors++; $display("FAIL coinc_setup: got %b expected 1", mem_rvalid); end
    if_flush = 1'b1; if_nxt_pc = 32'h500;
    tick();
    if_flush = 1'b0; mem_ack = 1'b1;
    tick();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL coinc_stay_run: got %b expected 1", s_req); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL coinc_dropped: got %0d expected 0", got.size()); end
    run_until(1, 10);
    checks++;
    if (got.size() < 1) begin
      errors++; $display("FAIL coinc_count: got %0d expected 1", got.size());
    end else begin
      checks++; if (got[0].pc !== 32'h500) begin errors++; $display("FAIL coinc_pc: got %h expected 500", got[0].pc); end
    end
  endtask

  task automatic test_misaligned();
    do_reset(32'h202);
    pc_auto = 1'b0;
    run_until(1, 10);
    checks++; if (acc_log.size() != 0) begin errors++; $display("FAIL mis_no_req: got %0d expected 0", acc_log.size()); end
    checks++;
    if (got.size() < 1) begin
      errors++; $display("FAIL mis_count: got %0d expected 1", got.size());
    end else begin
      checks++; if (got[0].pc !== 32'h202) begin errors++; $display("FAIL mis_pc: got %h expected 202", got[0].pc); end
      checks++; if (got[0].mis !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", got[0].mis); end
      checks++; if (got[0].data !== '0) begin errors++; $display("FAIL mis_data: got %h expected 0", got[0].data); end
      checks++; if (got[0].pf !== 1'b0) begin errors++; $display("FAIL mis_pf: got %b expected 0", got[0].pf); end
      checks++; if (got[0].v !== VALL) begin errors++; $display("FAIL mis_valid: got %b expected %b", got[0].v, VALL); end
    end
  endtask

  task automatic test_err_and_reset();
    do_reset(32'h2F8);
    err_adr = 32'h300;
    run_until(3, 20);
    checks++;
    if (got.size() < 3) begin
      errors++; $display("FAIL err_count: got %0d expected 3", got.size());
    end else begin
      checks++; if (got[1].pf !== 1'b0 || got[1].pc !== 32'h2FC) begin errors++; $display("FAIL err_clean: got pc %h pf %b expected 2fc 0", got[1].pc, got[1].pf); end
      checks++; if (got[2].pc !== 32'h300) begin errors++; $display("FAIL err_pc: got %h expected 300", got[2].pc); end
      checks++; if (got[2].pf !== 1'b1) begin errors++; $display("FAIL err_pf: got %b expected 1", got[2].pf); end
      checks++; if (got[2].data !== mdata(32'h300)) begin errors++; $display("FAIL err_data: got %h expected %h", got[2].data, mdata(32'h300)); end
    end
    rst = 1'b1;
    mem_rvalid = 1'b0; pend.delete();
    #1;
    checks++; if (if_parcel_valid !== '0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", if_parcel_valid); end
    checks++; if (if_parcel_pc !== '0) begin errors++; $display("FAIL midrst_pc: got %h expected 0", if_parcel_pc); end
    checks++; if (if_parcel !== '0) begin errors++; $display("FAIL midrst_parcel: got %h expected 0", if_parcel); end
    checks++; if (if_parcel_page_fault !== 1'b0 || if_parcel_misaligned !== 1'b0) begin errors++; $display("FAIL midrst_flags: got %b%b expected 00", if_parcel_page_fault, if_parcel_misaligned); end
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b expected 0", mem_req); end
    checks++; if (if_stall_nxt_pc !== 1'b1) begin errors++; $display("FAIL midrst_stall_nxt: got %b expected 1", if_stall_nxt_pc); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_flush_drain();
    test_flush_with_rvalid();
    test_misaligned();
    test_err_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
